// File: rtl/ascon_inv_diffusion.sv
// Iterative inverse of the Ascon linear diffusion layer: computes L^63 on the
// 320-bit state by applying UNROLL chained forward-L copies per cycle.
module ascon_inv_diffusion #(
  parameter int UNROLL = 1
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [1:0]   fsm_state_o
);

  localparam int NB_CYC    = 63 / UNROLL;
  localparam int CNT_W_RAW = $clog2(NB_CYC + 1);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB_CYC - 1);
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  generate
    if (!(UNROLL == 1 || UNROLL == 3 || UNROLL == 7 ||
          UNROLL == 9 || UNROLL == 21 || UNROLL == 63)) begin : g_bad_unroll
      $error("ascon_inv_diffusion: UNROLL must be one of 1, 3, 7, 9, 21, 63");
    end
  endgenerate

  // Handshake: start_i is a request accepted on any edge where busy_o = 0
  // (IDLE or DONE); done_o is a one-cycle pulse qualifying state_o, which then
  // holds until the next accepted request. There is no back-pressure on done_o.
  // fsm_state_o encoding: 0 = IDLE, 1 = RUN, 2 = DONE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [319:0]     work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [319:0]     mixed;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int r);
    return (x >> r) | (x << (64 - r));
  endfunction

  function automatic logic [319:0] lin_state(input logic [319:0] s);
    logic [319:0] res;
    logic [63:0]  w;
    res = '0;
    for (int k = 0; k < 5; k++) begin
      w = s[64*k +: 64];
      res[64*k +: 64] = w ^ ror64(w, ROT_A[k]) ^ ror64(w, ROT_B[k]);
    end
    return res;
  endfunction

  always_comb begin
    mixed = work_q;
    for (int i = 0; i < UNROLL; i++) begin
      mixed = lin_state(mixed);
    end
  end

  always_comb begin
    fsm_d  = fsm_q;
    work_d = work_q;
    cnt_d  = cnt_q;
    case (fsm_q)
      S_IDLE: begin
        if (start_i) begin
          work_d = state_i;
          cnt_d  = '0;
          fsm_d  = S_RUN;
        end
      end
      S_RUN: begin
        work_d = mixed;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          fsm_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start_i) begin
          work_d = state_i;
          cnt_d  = '0;
          fsm_d  = S_RUN;
        end else begin
          fsm_d = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q  <= S_IDLE;
      work_q <= '0;
      cnt_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      work_q <= work_d;
      cnt_q  <= cnt_d;
    end
  end

  assign state_o     = work_q;
  assign busy_o      = (fsm_q == S_RUN);
  assign done_o      = (fsm_q == S_DONE);
  assign fsm_state_o = fsm_q;

endmodule

// File: tb/tb_ascon_inv_diffusion.sv
// Self-checking bench for ascon_inv_diffusion: random round trips through a
// bit-level forward-L model, directed corner cases, and all legal UNROLL values.
module tb_ascon_inv_diffusion;

  localparam int NB1 = 63;
  localparam logic [319:0] IMPULSE = {64'h0200_0000_0080_0001, 64'h0040_8000_0000_0001,
                                      64'h8400_0000_0000_0001, 64'h0000_0000_0200_0009,
                                      64'h0000_2010_0000_0001};
  localparam logic [319:0] ONES_LSB = {5{64'h0000_0000_0000_0001}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n;
  logic rst_g;
  initial begin
    rst_g = 1'b0;
    #23 rst_g = 1'b1;
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // ROR(x,r) bit i is x bit (i+r) mod 64; L = x ^ ROR(x,ra) ^ ROR(x,rb) per word.
  function automatic logic [319:0] fwd(input logic [319:0] s);
    int ra [5];
    int rb [5];
    logic [319:0] r;
    ra = '{19, 61, 1, 10, 7};
    rb = '{28, 39, 6, 17, 41};
    r = '0;
    for (int w = 0; w < 5; w++)
      for (int i = 0; i < 64; i++)
        r[64*w+i] = s[64*w+i] ^ s[64*w+((i+ra[w])%64)] ^ s[64*w+((i+rb[w])%64)];
    return r;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- main DUT (UNROLL = 1) ----------------
  logic         start;
  logic [319:0] st_in, st_out;
  logic         busy, done;
  logic [1:0]   dbg;

  ascon_inv_diffusion #(.UNROLL(1)) u_dut (
    .clock_i    (clk),
    .resetb_i   (rst_n),
    .start_i    (start),
    .state_i    (st_in),
    .state_o    (st_out),
    .busy_o     (busy),
    .done_o     (done),
    .fsm_state_o(dbg)
  );

  logic [319:0] exp_q[$];
  int           acc_q[$];
  logic         btb_mode;
  int           last_done;
  logic         main_fin;

  // Scoreboard: every done pulse must match the oldest accepted request.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk_int("spurious_done", 1, 0);
      end else begin
        chk("result", st_out, exp_q.pop_front());
        chk_int("latency", cyc - acc_q.pop_front(), NB1 + 1);
        chk_int("busy_in_done", int'(busy), 0);
        chk_int("dbg_done", int'(dbg), 2);
        if (btb_mode && last_done >= 0) chk_int("btb_period", cyc - last_done, NB1 + 1);
        last_done = cyc;
      end
    end else if (btb_mode && exp_q.size() != 0) begin
      chk_int("btb_busy", int'(busy), 1);
    end
  end

  // Request on the next edge; caller guarantees the DUT is not in RUN.
  task automatic drive_one(input logic [319:0] din, input logic [319:0] expv);
    int n;
    n = 0;
    while (busy && n < NB1 + 4) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    st_in = din;
    exp_q.push_back(expv);
    acc_q.push_back(cyc);
    @(negedge clk);
    start = 1'b0;
    st_in = rand320();
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk_int("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  initial begin : main_drv
    logic [319:0] x;
    int n;
    main_fin  = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    st_in     = '0;
    btb_mode  = 1'b0;
    last_done = -1;
    repeat (3) @(negedge clk);
    chk("rst_state", st_out, '0);
    chk_int("rst_busy", int'(busy), 0);
    chk_int("rst_done", int'(done), 0);
    chk_int("rst_dbg", int'(dbg), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Pin the model with hand-computed values.
    chk("model_impulse", fwd(ONES_LSB), IMPULSE);
    chk("model_ones", fwd({320{1'b1}}), {320{1'b1}});

    // Impulse inverse, then check state_o is held after done.
    drive_one(IMPULSE, ONES_LSB);
    wait_drain(NB1 + 10);
    repeat (2) @(negedge clk);
    chk("hold_after_done", st_out, ONES_LSB);

    drive_one('0, '0);
    wait_drain(NB1 + 10);
    drive_one({320{1'b1}}, {320{1'b1}});
    wait_drain(NB1 + 10);

    repeat (150) begin
      x = rand320();
      drive_one(fwd(x), x);
      wait_drain(NB1 + 10);
    end

    // Busy protection: new requests on every RUN cycle are ignored.
    x = rand320();
    drive_one(fwd(x), x);
    for (int k = 1; k <= NB1; k++) begin
      start = 1'b1;
      st_in = rand320();
      @(negedge clk);
    end
    start = 1'b0;
    wait_drain(10);
    repeat (3) @(negedge clk);
    chk_int("bp_no_requeue", int'(busy), 0);

    // Back-to-back: start held high, fresh data in every DONE cycle.
    x = rand320();
    start = 1'b1;
    st_in = fwd(x);
    exp_q.push_back(x);
    acc_q.push_back(cyc);
    @(negedge clk);
    last_done = -1;
    btb_mode  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      n = 0;
      while (!done && n < NB1 + 10) begin
        @(negedge clk);
        n++;
      end
      if (!done) begin
        chk_int("btb_timeout", 0, 1);
        break;
      end
      if (k < 20) begin
        x = rand320();
        st_in = fwd(x);
        exp_q.push_back(x);
        acc_q.push_back(cyc);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start    = 1'b0;
    btb_mode = 1'b0;
    wait_drain(NB1 + 10);

    // Reset in the middle of RUN aborts without a done pulse.
    x = rand320();
    drive_one(fwd(x), x);
    repeat (29) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_state", st_out, '0);
    chk_int("mid_rst_busy", int'(busy), 0);
    chk_int("mid_rst_done", int'(done), 0);
    exp_q.delete();
    acc_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    x = rand320();
    drive_one(fwd(x), x);
    wait_drain(NB1 + 10);
    main_fin = 1'b1;
  end

  // ---------------- other legal UNROLL values ----------------
  for (genvar gi = 0; gi < 5; gi++) begin : g_u
    localparam int U  = (gi == 0) ? 3 : (gi == 1) ? 7 : (gi == 2) ? 9 : (gi == 3) ? 21 : 63;
    localparam int NB = 63 / U;

    logic         g_start;
    logic [319:0] g_in, g_out;
    logic         g_busy, g_done;
    logic [1:0]   g_dbg;
    logic [319:0] g_exp_q[$];
    int           g_acc_q[$];
    logic         g_fin;

    ascon_inv_diffusion #(.UNROLL(U)) u_dut (
      .clock_i    (clk),
      .resetb_i   (rst_g),
      .start_i    (g_start),
      .state_i    (g_in),
      .state_o    (g_out),
      .busy_o     (g_busy),
      .done_o     (g_done),
      .fsm_state_o(g_dbg)
    );

    always @(negedge clk) begin
      if (g_done) begin
        if (g_exp_q.size() == 0) begin
          chk_int($sformatf("spurious_done_u%0d", U), 1, 0);
        end else begin
          chk($sformatf("roundtrip_u%0d", U), g_out, g_exp_q.pop_front());
          chk_int($sformatf("latency_u%0d", U), cyc - g_acc_q.pop_front(), NB + 1);
          chk_int($sformatf("dbg_done_u%0d", U), int'(g_dbg), 2);
        end
      end
    end

    initial begin : drv
      logic [319:0] x;
      int n;
      g_fin   = 1'b0;
      g_start = 1'b0;
      g_in    = '0;
      wait (rst_g === 1'b1);
      @(negedge clk);
      for (int k = 0; k < 1000; k++) begin
        n = 0;
        while (g_busy && n < NB + 4) begin
          @(negedge clk);
          n++;
        end
        x = rand320();
        g_start = 1'b1;
        g_in    = fwd(x);
        g_exp_q.push_back(x);
        g_acc_q.push_back(cyc);
        @(negedge clk);
        g_start = 1'b0;
      end
      n = 0;
      while (g_exp_q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (g_exp_q.size() != 0) chk_int($sformatf("drain_u%0d", U), g_exp_q.size(), 0);
      g_fin = 1'b1;
    end
  end

  // ---------------- final report ----------------
  initial begin : report
    int n;
    n = 0;
    while (!(main_fin && g_u[0].g_fin && g_u[1].g_fin && g_u[2].g_fin &&
             g_u[3].g_fin && g_u[4].g_fin) && n < 60000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60000) chk_int("global_timeout", n, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
